fb_mem_port_mux: RTL and testbench

- Downstream consumer of the 2-requester round-robin arbiter (rrarb) in the frame-buffer memory path.
- Collects burst requests from two clients (e.g. display read, capture write) and forwards them to rrarb as `request[1:0]`.
- Takes rrarb's `grant[1:0]` and runs the granted client's burst on a single memory command/response interface.
- Serialises all traffic: only one client owns the memory from grant acceptance until that client's done pulse.

---
 rtl/fb_pkg.sv | 18 +
 rtl/fb_burst_ctr.sv | 51 +++++
 rtl/fb_mem_port_mux.sv | 113 +++++++++++
 tb/tb_fb_mem_port_mux.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and defaults for the frame-buffer memory port multiplexer.
package fb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fb_state_e;

  localparam logic CLI_DISP = 1'b0;
  localparam logic CLI_CAP  = 1'b1;

  localparam int unsigned FB_AW = 20;
  localparam int unsigned FB_DW = 16;
  localparam int unsigned FB_LW = 4;

endpackage

// File: rtl/fb_burst_ctr.sv
// Beat counter and outstanding-read counter for one burst, with last-beat and drained flags.
module fb_burst_ctr #(
  parameter int unsigned LW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          beat_inc_i,
  input  logic          rd_issue_i,
  input  logic          rd_ret_i,
  input  logic [LW-1:0] len_i,
  output logic [LW-1:0] beat_o,
  output logic          last_beat_o,
  output logic          drained_o
);

  logic [LW-1:0] beat_q, beat_d;
  logic [LW:0]   outst_q, outst_d;

  always_comb begin
    beat_d  = beat_q;
    outst_d = outst_q;
    if (clr_i) begin
      beat_d  = '0;
      outst_d = '0;
    end else begin
      if (beat_inc_i) beat_d = beat_q + LW'(1);
      // Simultaneous issue and return cancel out.
      case ({rd_issue_i, rd_ret_i})
        2'b10:   outst_d = outst_q + (LW+1)'(1);
        2'b01:   outst_d = outst_q - (LW+1)'(1);
        default: outst_d = outst_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_q  <= '0;
      outst_q <= '0;
    end else begin
      beat_q  <= beat_d;
      outst_q <= outst_d;
    end
  end

  assign beat_o      = beat_q;
  assign last_beat_o = (beat_q == len_i);
  assign drained_o   = rd_ret_i && !rd_issue_i && (outst_q == (LW+1)'(1));

endmodule

// File: rtl/fb_mem_port_mux.sv
// Two-client burst multiplexer onto a single memory command/response port, driven by rrarb grants.
module fb_mem_port_mux
  import fb_pkg::*;
#(
  parameter int unsigned AW = FB_AW,
  parameter int unsigned DW = FB_DW,
  parameter int unsigned LW = FB_LW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    cli_req,
  input  logic [1:0]    cli_we,
  input  logic [2*AW-1:0] cli_addr,
  input  logic [2*LW-1:0] cli_len,
  input  logic [2*DW-1:0] cli_wdata,
  output logic [1:0]    cli_wready,
  output logic [DW-1:0] cli_rdata,
  output logic [1:0]    cli_rvalid,
  output logic [1:0]    cli_done,
  output logic [1:0]    arb_request,
  input  logic [1:0]    arb_grant,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);

  fb_state_e     state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] beat;
  logic          grant_idx, grant_ok, accept, fire, active, rd_ret, last_beat, drained;
  logic [1:0]    owner_oh;

  assign grant_idx = arb_grant[1];
  assign grant_ok  = ((arb_grant == 2'b01) || (arb_grant == 2'b10)) && ((cli_req & arb_grant) != 2'b00);
  assign accept    = (state_q == IDLE) && grant_ok;
  assign fire      = (state_q == XFER) && mem_ready;
  assign active    = (state_q == XFER) || (state_q == DRAIN);
  assign rd_ret    = active && mem_rvalid;
  assign owner_oh  = (owner_q == CLI_CAP) ? 2'b10 : 2'b01;

  fb_burst_ctr #(.LW(LW)) u_ctr (
    .clk_i       (clk),
    .rst_i       (reset),
    .clr_i       (accept),
    .beat_inc_i  (fire),
    .rd_issue_i  (fire && !we_q),
    .rd_ret_i    (rd_ret),
    .len_i       (len_q),
    .beat_o      (beat),
    .last_beat_o (last_beat),
    .drained_o   (drained)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (grant_ok) begin
          owner_d = grant_idx ? CLI_CAP : CLI_DISP;
          we_d    = cli_we[grant_idx];
          addr_d  = grant_idx ? cli_addr[AW +: AW] : cli_addr[0 +: AW];
          len_d   = grant_idx ? cli_len[LW +: LW] : cli_len[0 +: LW];
          state_d = XFER;
        end
      end
      XFER:    if (fire && last_beat) state_d = we_q ? DONE : DRAIN;
      DRAIN:   if (drained) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= CLI_DISP;
      we_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
    end
  end

  // Command fields are zeroed outside XFER so idle outputs match the reset image.
  always_comb begin
    mem_valid   = (state_q == XFER);
    mem_we      = mem_valid && we_q;
    mem_addr    = mem_valid ? (addr_q + AW'(beat)) : '0;
    mem_wdata   = '0;
    if (mem_valid) mem_wdata = (owner_q == CLI_CAP) ? cli_wdata[DW +: DW] : cli_wdata[0 +: DW];
    cli_wready  = (fire && we_q) ? owner_oh : 2'b00;
    cli_rvalid  = rd_ret ? owner_oh : 2'b00;
    cli_rdata   = active ? mem_rdata : '0;
    cli_done    = (state_q == DONE) ? owner_oh : 2'b00;
    arb_request = cli_req & ~cli_done;
  end

endmodule

// File: tb/tb_fb_mem_port_mux.sv
// Bench for fb_mem_port_mux: directed literal cases plus randomized traffic against a burst-level model.
module tb_fb_mem_port_mux;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]    cli_req, cli_we, cli_wready, cli_rvalid, cli_done, arb_request, arb_grant;
  logic [AW-1:0] c_addr[2];
  logic [LW-1:0] c_len[2];
  logic [DW-1:0] c_wdata[2];
  logic [2*AW-1:0] cli_addr;
  logic [2*LW-1:0] cli_len;
  logic [2*DW-1:0] cli_wdata;
  logic [DW-1:0] cli_rdata, mem_wdata, mem_rdata;
  logic          mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [AW-1:0] mem_addr;

  assign cli_addr  = {c_addr[1], c_addr[0]};
  assign cli_len   = {c_len[1], c_len[0]};
  assign cli_wdata = {c_wdata[1], c_wdata[0]};

  fb_mem_port_mux #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk(clk), .reset(reset),
    .cli_req(cli_req), .cli_we(cli_we), .cli_addr(cli_addr), .cli_len(cli_len),
    .cli_wdata(cli_wdata), .cli_wready(cli_wready), .cli_rdata(cli_rdata),
    .cli_rvalid(cli_rvalid), .cli_done(cli_done), .arb_request(arb_request),
    .arb_grant(arb_grant), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Burst-level model: a granted burst owns the port until all beats issued and all reads returned.
  bit            chk_en = 1'b0;
  bit            m_busy = 1'b0;
  bit            m_own = 1'b0;
  bit            m_we = 1'b0;
  logic [AW-1:0] m_base = '0;
  int            m_total = 0, m_issued = 0, m_pend = 0;
  int            acc_cnt[2] = '{0, 0};

  always @(negedge clk) begin
    if (chk_en) begin
      bit v, fire, dn, act;
      logic [1:0] oh, ear;
      logic [AW-1:0] ea;
      oh   = m_own ? 2'b10 : 2'b01;
      v    = m_busy && (m_issued < m_total);
      dn   = m_busy && (m_issued == m_total) && (m_pend == 0);
      act  = m_busy && !dn;
      fire = v && mem_ready;
      ea   = m_base + AW'(m_issued);
      ear  = cli_req & ~(dn ? oh : 2'b00);
      chk("mem_valid", mem_valid, v);
      chk("mem_we", mem_we, v && m_we);
      chk("mem_addr", mem_addr, v ? ea : '0);
      chk("mem_wdata", mem_wdata, v ? c_wdata[m_own] : '0);
      chk("cli_wready", cli_wready, (fire && m_we) ? oh : 2'b00);
      chk("cli_rvalid", cli_rvalid, (act && mem_rvalid) ? oh : 2'b00);
      chk("cli_rdata", cli_rdata, act ? mem_rdata : '0);
      chk("cli_done", cli_done, dn ? oh : 2'b00);
      chk("arb_request", arb_request, ear);
      if (reset) m_busy = 1'b0;
      else if (!m_busy) begin
        if (((arb_grant == 2'b01) || (arb_grant == 2'b10)) && ((cli_req & arb_grant) != 2'b00)) begin
          m_busy   = 1'b1;
          m_own    = arb_grant[1];
          m_we     = cli_we[m_own];
          m_base   = c_addr[m_own];
          m_total  = int'(c_len[m_own]) + 1;
          m_issued = 0;
          m_pend   = 0;
          acc_cnt[m_own]++;
        end
      end else if (dn) m_busy = 1'b0;
      else begin
        if (fire) begin
          m_issued++;
          if (!m_we) m_pend++;
        end
        if (mem_rvalid) m_pend--;
      end
    end
  end

  task automatic dir_write(input bit idx, input logic [AW-1:0] base, input logic [LW-1:0] len,
                           input logic [7:0] rdy, input logic [AW-1:0] ea[8], input int done_at,
                           input string nm);
    int nbeat;
    logic [1:0] oh;
    nbeat = 0;
    oh = idx ? 2'b10 : 2'b01;
    @(posedge clk); #1;
    cli_req = oh; cli_we = oh; c_addr[idx] = base; c_len[idx] = len;
    c_wdata[idx] = 16'hA000; arb_grant = oh; mem_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_grant_cycle_valid"}, mem_valid, 1'b0);
    for (int k = 1; k <= done_at; k++) begin
      @(posedge clk); #1;
      arb_grant = 2'b00;
      mem_ready = rdy[k-1];
      c_wdata[idx] = 16'hA000 + 16'(nbeat);
      @(negedge clk);
      if (k < done_at) begin
        chk({nm, "_valid"}, mem_valid, 1'b1);
        chk({nm, "_addr"}, mem_addr, ea[k-1]);
        chk({nm, "_wdata"}, mem_wdata, 16'hA000 + 16'(nbeat));
        chk({nm, "_nodone"}, cli_done, 2'b00);
      end else begin
        chk({nm, "_done"}, cli_done, oh);
        chk({nm, "_req_masked"}, arb_request & oh, 2'b00);
      end
      if (cli_wready[idx]) nbeat++;
    end
    chk({nm, "_beats"}, nbeat, int'(len) + 1);
    @(posedge clk); #1;
    cli_req = 2'b00;
    @(negedge clk);
    chk({nm, "_done_clear"}, cli_done, 2'b00);
  endtask

  typedef struct {
    int t;
    logic [DW-1:0] d;
  } ret_t;
  ret_t rq[$];

  initial begin
    logic [AW-1:0] ea[8];
    logic [1:0] s_done, s_wready, s_areq, g;
    int cyc, last_t, rcnt, a0, a1, dcnt0, dcnt1, x;
    bit quiet;

    reset = 1'b1; cli_req = '0; cli_we = '0; arb_grant = '0;
    c_addr = '{'0, '0}; c_len = '{'0, '0}; c_wdata = '{'0, '0};
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1; chk_en = 1'b1;
    @(negedge clk);
    chk("reset_valid", mem_valid, 1'b0);
    chk("reset_done", cli_done, 2'b00);
    chk("reset_addr", mem_addr, '0);
    @(posedge clk); #1; reset = 1'b0;

    ea = '{20'h00100, 20'h00101, 20'h00102, 20'h00103, '0, '0, '0, '0};
    dir_write(1'b0, 20'h00100, 4'd3, 8'hFF, ea, 5, "wr_c0");

    ea = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001, '0, '0, '0, '0};
    dir_write(1'b1, 20'hFFFFE, 4'd3, 8'hFF, ea, 5, "wrap");

    ea = '{20'h00300, 20'h00301, 20'h00301, 20'h00301, 20'h00302, 20'h00303, 20'h00303, '0};
    dir_write(1'b0, 20'h00300, 4'd3, 8'h59, ea, 8, "bp");

    // Read, client 1, two beats, memory latency 3.
    @(posedge clk); #1;
    cli_req = 2'b10; cli_we = 2'b00; c_addr[1] = 20'h02000; c_len[1] = 4'd1;
    arb_grant = 2'b10; mem_ready = 1'b1;
    @(negedge clk);
    rcnt = 0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      arb_grant = 2'b00;
      mem_rvalid = (k == 4) || (k == 5);
      mem_rdata = (k == 4) ? 16'h1111 : (k == 5) ? 16'h2222 : 16'h0000;
      @(negedge clk);
      chk("rd_valid", mem_valid, (k <= 2));
      if (k <= 2) chk("rd_addr", mem_addr, 20'h02000 + 20'(k - 1));
      if (k == 4) chk("rd_data1", cli_rdata, 16'h1111);
      if (k == 5) chk("rd_data2", cli_rdata, 16'h2222);
      chk("rd_rvalid0", cli_rvalid[0], 1'b0);
      chk("rd_done", cli_done, (k == 6) ? 2'b10 : 2'b00);
      if (cli_rvalid[1]) rcnt++;
      if (k == 6) cli_req = 2'b00;
    end
    mem_rvalid = 1'b0;
    chk("rd_pulses", rcnt, 2);

    // Illegal grants: both bits set, then a grant to a non-requesting client.
    for (int k = 0; k <= 4; k++) begin
      @(posedge clk); #1;
      cli_req   = (k < 3) ? 2'b11 : (k == 3) ? 2'b01 : 2'b00;
      cli_we    = 2'b11;
      arb_grant = (k < 3) ? 2'b11 : (k == 3) ? 2'b10 : 2'b00;
      @(negedge clk);
      chk("badgrant_valid", mem_valid, 1'b0);
    end

    // Reset after two write beats, with a late read return afterwards.
    @(posedge clk); #1;
    cli_req = 2'b01; cli_we = 2'b01; c_addr[0] = 20'h00500; c_len[0] = 4'd7;
    c_wdata[0] = 16'hC000; arb_grant = 2'b01; mem_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      arb_grant = 2'b00;
      reset = (k == 3);
      if (k >= 3) cli_req = 2'b00;
      mem_rvalid = (k == 4);
      mem_rdata = (k == 4) ? 16'hBEEF : 16'h0000;
      @(negedge clk);
      if (k <= 2) chk("rst_wready", cli_wready, 2'b01);
      if (k == 4) begin
        chk("rst_valid", mem_valid, 1'b0);
        chk("rst_wready0", cli_wready, 2'b00);
        chk("rst_rvalid", cli_rvalid, 2'b00);
        chk("rst_rdata", cli_rdata, '0);
        chk("rst_addr", mem_addr, '0);
        chk("rst_areq", arb_request, 2'b00);
      end
      if (k >= 4) chk("rst_nodone", cli_done, 2'b00);
    end
    mem_rvalid = 1'b0;
    ea = '{20'h00040, '0, '0, '0, '0, '0, '0, '0};
    dir_write(1'b0, 20'h00040, 4'd0, 8'hFF, ea, 2, "post_rst");

    // Randomized traffic with a round-robin arbiter and an in-order variable-latency memory.
    s_done = '0; s_wready = '0; s_areq = '0;
    cyc = 0; last_t = 0; dcnt0 = 0; dcnt1 = 0;
    a0 = acc_cnt[0]; a1 = acc_cnt[1];
    for (int c = 0; c < 3000; c++) begin
      quiet = (c >= 2880);
      @(posedge clk); cyc++; #1;
      for (int i = 0; i < 2; i++) begin
        if (cli_req[i]) begin
          if (s_done[i]) cli_req[i] = 1'b0;
          else if (s_wready[i]) c_wdata[i] = DW'($urandom);
        end else if (!quiet && $urandom_range(3) == 0) begin
          cli_req[i] = 1'b1;
          cli_we[i]  = 1'($urandom);
          c_addr[i]  = ($urandom_range(7) == 0) ? (20'hFFFF8 + 20'($urandom_range(7))) : AW'($urandom);
          c_len[i]   = ($urandom_range(1) == 0) ? LW'($urandom_range(3)) : LW'($urandom);
          c_wdata[i] = DW'($urandom);
        end
      end
      x = $urandom_range(19);
      if (!quiet && x == 0) g = 2'b11;
      else if (!quiet && x == 1) g = (s_areq == 2'b01) ? 2'b10 : (s_areq == 2'b10) ? 2'b01 : 2'b00;
      else if (s_areq == 2'b11) g = m_own ? 2'b01 : 2'b10;
      else g = s_areq;
      arb_grant = g;
      mem_ready = ($urandom_range(3) != 0);
      mem_rvalid = 1'b0;
      mem_rdata = DW'($urandom);
      if (rq.size() > 0 && rq[0].t <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata = rq[0].d;
        void'(rq.pop_front());
      end
      @(negedge clk);
      s_done = cli_done; s_wready = cli_wready; s_areq = arb_request;
      if (cli_done[0]) dcnt0++;
      if (cli_done[1]) dcnt1++;
      if (mem_valid && mem_ready && !mem_we) begin
        ret_t r;
        r.t = cyc + int'($urandom_range(1, 4));
        if (r.t <= last_t) r.t = last_t + 1;
        r.d = DW'($urandom);
        last_t = r.t;
        rq.push_back(r);
      end
    end
    chk("rand_done_c0", dcnt0, acc_cnt[0] - a0);
    chk("rand_done_c1", dcnt1, acc_cnt[1] - a1);
    chk("rand_traffic", ((acc_cnt[0] - a0) > 5) && ((acc_cnt[1] - a1) > 5), 1'b1);
    chk("final_idle", mem_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
